cache_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single 128-bit line-fill/write-back memory port between the instruction cache (master 0) and the data cache (master 1). It sits between the two `cache` instances' `o_m_*`/`i_m_*` ports and the external memory model or controller. It holds one memory transaction at a time, using fair round-robin selection and a grant lock until completion. It also counts grants per master for performance reporting.

---
 rtl/cache_arb_pkg.sv | 17 +
 rtl/cache_mem_arbiter_rr_arb2.sv | 15 +
 rtl/cache_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the two-master cache memory arbiter.
// Imported by the round-robin picker and the arbiter top level.
package cache_arb_pkg;

  localparam int ARB_ADDR_W = 26;
  localparam int ARB_DATA_W = 128;
  localparam int ARB_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

endpackage : cache_arb_pkg

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins, and on a tie
// the master that was not served last wins.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  master_id_t  last,
  output logic        gnt_valid,
  output master_id_t  gnt_id
);

  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? ~last : req[1];

endmodule : rr_arb2

// File: rtl/cache_mem_arbiter.sv
// Shares one line-fill/write-back memory port between the I-cache (master 0)
// and D-cache (master 1); one transaction in flight, grant held to completion.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int BE_W   = ARB_BE_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_c0_addr,
  input  logic [BE_W-1:0]   i_c0_byte_en,
  input  logic [DATA_W-1:0] i_c0_writedata,
  input  logic              i_c0_read,
  input  logic              i_c0_write,
  output logic [DATA_W-1:0] o_c0_readdata,
  output logic              o_c0_readdata_valid,
  output logic              o_c0_waitrequest,

  input  logic [ADDR_W-1:0] i_c1_addr,
  input  logic [BE_W-1:0]   i_c1_byte_en,
  input  logic [DATA_W-1:0] i_c1_writedata,
  input  logic              i_c1_read,
  input  logic              i_c1_write,
  output logic [DATA_W-1:0] o_c1_readdata,
  output logic              o_c1_readdata_valid,
  output logic              o_c1_waitrequest,

  output logic [ADDR_W-1:0] o_m_addr,
  output logic [BE_W-1:0]   o_m_byte_en,
  output logic [DATA_W-1:0] o_m_writedata,
  output logic              o_m_read,
  output logic              o_m_write,
  input  logic [DATA_W-1:0] i_m_readdata,
  input  logic              i_m_readdata_valid,
  input  logic              i_m_waitrequest,

  output logic [31:0]       o_grant_cnt0,
  output logic [31:0]       o_grant_cnt1,
  output logic              o_proto_err
);

  arb_state_t  state_q, state_d;
  master_id_t  gnt_q, gnt_d;
  master_id_t  last_q, last_d;
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;
  logic        perr_q, perr_d;

  logic [1:0]  req;
  logic        arb_valid;
  master_id_t  arb_id;
  logic        sel_read;
  logic        sel_write;
  logic        accept;

  assign req = {i_c1_read | i_c1_write, i_c0_read | i_c0_write};

  rr_arb2 u_rr_arb2 (
    .req       (req),
    .last      (last_q),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  // A read+write collision from the granted master is serviced as a write.
  assign sel_write = gnt_q ? i_c1_write : i_c0_write;
  assign sel_read  = (gnt_q ? i_c1_read : i_c0_read) & ~sel_write;
  assign accept    = (state_q == CMD) & (sel_read | sel_write) & ~i_m_waitrequest;

  // Read data is broadcast; only the valid strobe is steered to its owner.
  assign o_c0_readdata = i_m_readdata;
  assign o_c1_readdata = i_m_readdata;

  assign o_m_addr      = gnt_q ? i_c1_addr      : i_c0_addr;
  assign o_m_byte_en   = gnt_q ? i_c1_byte_en   : i_c0_byte_en;
  assign o_m_writedata = gnt_q ? i_c1_writedata : i_c0_writedata;

  assign o_grant_cnt0 = cnt0_q;
  assign o_grant_cnt1 = cnt1_q;
  assign o_proto_err  = perr_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d             = state_q;
    gnt_d               = gnt_q;
    last_d              = last_q;
    cnt0_d              = cnt0_q;
    cnt1_d              = cnt1_q;
    perr_d              = perr_q | (i_c0_read & i_c0_write) | (i_c1_read & i_c1_write);
    o_c0_waitrequest    = 1'b1;
    o_c1_waitrequest    = 1'b1;
    o_c0_readdata_valid = 1'b0;
    o_c1_readdata_valid = 1'b0;
    o_m_read            = 1'b0;
    o_m_write           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_id;
          state_d = CMD;
          if (arb_id) cnt1_d = cnt1_q + 32'd1;
          else        cnt0_d = cnt0_q + 32'd1;
        end
      end

      CMD: begin
        o_m_read  = sel_read;
        o_m_write = sel_write;
        if (gnt_q) o_c1_waitrequest = i_m_waitrequest;
        else       o_c0_waitrequest = i_m_waitrequest;
        if (accept) begin
          if (sel_write) begin
            last_d  = gnt_q;
            state_d = IDLE;
          end else begin
            state_d = RDATA;
          end
        end
      end

      RDATA: begin
        if (gnt_q) o_c1_readdata_valid = i_m_readdata_valid;
        else       o_c0_readdata_valid = i_m_readdata_valid;
        if (i_m_readdata_valid) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      perr_q  <= perr_d;
    end
  end

endmodule : cache_mem_arbiter

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected commands and read lines are
// queued per master at stimulus time and consumed when the DUT produces them.
module tb_cache_mem_arbiter;

  localparam int AW = 26;
  localparam int DW = 128;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_c0_addr, i_c1_addr;
  logic [BW-1:0] i_c0_byte_en, i_c1_byte_en;
  logic [DW-1:0] i_c0_writedata, i_c1_writedata;
  logic          i_c0_read, i_c0_write, i_c1_read, i_c1_write;
  logic [DW-1:0] o_c0_readdata, o_c1_readdata;
  logic          o_c0_readdata_valid, o_c1_readdata_valid;
  logic          o_c0_waitrequest, o_c1_waitrequest;
  logic [AW-1:0] o_m_addr;
  logic [BW-1:0] o_m_byte_en;
  logic [DW-1:0] o_m_writedata;
  logic          o_m_read, o_m_write;
  logic [DW-1:0] i_m_readdata;
  logic          i_m_readdata_valid, i_m_waitrequest;
  logic [31:0]   o_grant_cnt0, o_grant_cnt1;
  logic          o_proto_err;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_c0_addr           (i_c0_addr),
    .i_c0_byte_en        (i_c0_byte_en),
    .i_c0_writedata      (i_c0_writedata),
    .i_c0_read           (i_c0_read),
    .i_c0_write          (i_c0_write),
    .o_c0_readdata       (o_c0_readdata),
    .o_c0_readdata_valid (o_c0_readdata_valid),
    .o_c0_waitrequest    (o_c0_waitrequest),
    .i_c1_addr           (i_c1_addr),
    .i_c1_byte_en        (i_c1_byte_en),
    .i_c1_writedata      (i_c1_writedata),
    .i_c1_read           (i_c1_read),
    .i_c1_write          (i_c1_write),
    .o_c1_readdata       (o_c1_readdata),
    .o_c1_readdata_valid (o_c1_readdata_valid),
    .o_c1_waitrequest    (o_c1_waitrequest),
    .o_m_addr            (o_m_addr),
    .o_m_byte_en         (o_m_byte_en),
    .o_m_writedata       (o_m_writedata),
    .o_m_read            (o_m_read),
    .o_m_write           (o_m_write),
    .i_m_readdata        (i_m_readdata),
    .i_m_readdata_valid  (i_m_readdata_valid),
    .i_m_waitrequest     (i_m_waitrequest),
    .o_grant_cnt0        (o_grant_cnt0),
    .o_grant_cnt1        (o_grant_cnt1),
    .o_proto_err         (o_proto_err)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          cmdq0[$], cmdq1[$];
  logic [DW-1:0] rdq0[$], rdq1[$];
  int            acc_log[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            stall_left = 0;
  int            mem_lat = 1;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_addr = '0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {4{{6'h2A, a}}};
  endfunction

  // Memory model: optional stall on a presented command, read data mem_lat cycles after accept.
  initial begin
    i_m_waitrequest    = 1'b0;
    i_m_readdata_valid = 1'b0;
    i_m_readdata       = '0;
    forever begin
      @(posedge clk);
      #1;
      i_m_readdata_valid = 1'b0;
      i_m_readdata       = '0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          i_m_readdata_valid = 1'b1;
          i_m_readdata       = mem_data(rd_addr);
        end
      end
      if ((o_m_read || o_m_write) && stall_left > 0) begin
        i_m_waitrequest = 1'b1;
        stall_left--;
      end else begin
        i_m_waitrequest = 1'b0;
      end
    end
  end

  // Monitor: command acceptance and steered read data, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (o_c0_readdata_valid) begin
        n_vec++;
        if (rdq0.size() == 0) begin
          n_err++;
          $display("FAIL c0_rdata: unexpected valid, data=%h", o_c0_readdata);
        end else begin
          logic [DW-1:0] e0;
          e0 = rdq0.pop_front();
          if (o_c0_readdata !== e0) begin
            n_err++;
            $display("FAIL c0_rdata: got %h want %h", o_c0_readdata, e0);
          end
        end
      end
      if (o_c1_readdata_valid) begin
        n_vec++;
        if (rdq1.size() == 0) begin
          n_err++;
          $display("FAIL c1_rdata: unexpected valid, data=%h", o_c1_readdata);
        end else begin
          logic [DW-1:0] e1;
          e1 = rdq1.pop_front();
          if (o_c1_readdata !== e1) begin
            n_err++;
            $display("FAIL c1_rdata: got %h want %h", o_c1_readdata, e1);
          end
        end
      end
      if (!rst && (o_m_read || o_m_write) && !i_m_waitrequest) begin
        int   m;
        cmd_t e;
        logic have;
        n_vec++;
        have = 1'b0;
        if (o_c0_waitrequest === 1'b0 && o_c1_waitrequest === 1'b1) m = 0;
        else if (o_c0_waitrequest === 1'b1 && o_c1_waitrequest === 1'b0) m = 1;
        else m = -1;
        if (m < 0) begin
          n_err++;
          $display("FAIL accept_owner: wait0=%b wait1=%b want exactly one 0",
                   o_c0_waitrequest, o_c1_waitrequest);
        end else if (m == 0 && cmdq0.size() != 0) begin
          e = cmdq0.pop_front();
          have = 1'b1;
        end else if (m == 1 && cmdq1.size() != 0) begin
          e = cmdq1.pop_front();
          have = 1'b1;
        end else begin
          n_err++;
          $display("FAIL accept_unexpected: master %0d addr=%h", m, o_m_addr);
        end
        if (have) begin
          acc_log.push_back(m);
          if ({o_m_read, o_m_write, o_m_addr, o_m_byte_en} !== {e.rd, e.wr, e.addr, e.be} ||
              (e.wr && o_m_writedata !== e.data)) begin
            n_err++;
            $display("FAIL accept_cmd m%0d: got rd=%b wr=%b a=%h be=%h d=%h want rd=%b wr=%b a=%h be=%h d=%h",
                     m, o_m_read, o_m_write, o_m_addr, o_m_byte_en, o_m_writedata,
                     e.rd, e.wr, e.addr, e.be, e.data);
          end
        end
        if (o_m_read) begin
          rd_cnt  = mem_lat;
          rd_addr = o_m_addr;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (m == 0) begin
      i_c0_read = rd; i_c0_write = wr; i_c0_addr = a; i_c0_byte_en = be; i_c0_writedata = d;
    end else begin
      i_c1_read = rd; i_c1_write = wr; i_c1_addr = a; i_c1_byte_en = be; i_c1_writedata = d;
    end
  endtask

  function automatic logic [BW-1:0] be_of(input logic [AW-1:0] a);
    return {a[1:0], 2'b11};
  endfunction

  // Queue the expectation, then hold the command until the arbiter lets it through.
  task automatic master_txn(input int m, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t e;
    logic done;
    logic w;
    done   = 1'b0;
    e.rd   = rd & ~wr;
    e.wr   = wr;
    e.addr = a;
    e.be   = be_of(a);
    e.data = d;
    if (m == 0) cmdq0.push_back(e);
    else        cmdq1.push_back(e);
    if (rd && !wr) begin
      if (m == 0) rdq0.push_back(mem_data(a));
      else        rdq1.push_back(mem_data(a));
    end
    drive(m, rd, wr, a, e.be, d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      w = (m == 0) ? o_c0_waitrequest : o_c1_waitrequest;
      if (w === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    drive(m, 1'b0, 1'b0, '0, '0, '0);
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL grant_timeout m%0d addr=%h: got no accept within 100 cycles, want accept", m, a);
    end
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while ((cmdq0.size() + cmdq1.size() + rdq0.size() + rdq1.size() != 0 || rd_cnt != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (i >= 200) begin
      n_err++;
      $display("FAIL %s_drain: pending cmd=%0d/%0d rd=%0d/%0d, want all empty",
               tag, cmdq0.size(), cmdq1.size(), rdq0.size(), rdq1.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    stall_left = 0;
    mem_lat    = 1;
    rd_cnt     = 0;
    cmdq0.delete(); cmdq1.delete(); rdq0.delete(); rdq1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({o_c0_waitrequest, o_c1_waitrequest, o_m_read, o_m_write,
         o_c0_readdata_valid, o_c1_readdata_valid, o_proto_err} !== 7'b1100000) begin
      n_err++;
      $display("FAIL reset_outputs: got w0=%b w1=%b rd=%b wr=%b v0=%b v1=%b perr=%b want 1100000",
               o_c0_waitrequest, o_c1_waitrequest, o_m_read, o_m_write,
               o_c0_readdata_valid, o_c1_readdata_valid, o_proto_err);
    end
    n_vec++;
    if (o_grant_cnt0 !== 32'd0 || o_grant_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", o_grant_cnt0, o_grant_cnt1);
    end
  endtask

  task automatic test_single_write();
    cmd_t e;
    do_reset();
    e.rd = 1'b0; e.wr = 1'b1; e.addr = 26'h10; e.be = be_of(26'h10); e.data = {16{8'hAA}};
    cmdq0.push_back(e);
    drive(0, 1'b0, 1'b1, e.addr, e.be, e.data);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (o_m_write !== 1'b1 || o_m_read !== 1'b0 || o_m_addr !== 26'h10 || o_m_writedata !== e.data) begin
      n_err++;
      $display("FAIL wr_cmd_cycle1: got wr=%b rd=%b a=%h want wr=1 rd=0 a=10", o_m_write, o_m_read, o_m_addr);
    end
    n_vec++;
    if (o_c0_waitrequest !== 1'b0 || o_c1_waitrequest !== 1'b1) begin
      n_err++;
      $display("FAIL wr_wait_cycle1: got w0=%b w1=%b want 0/1", o_c0_waitrequest, o_c1_waitrequest);
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    n_vec++;
    if (o_grant_cnt0 !== 32'd1 || o_grant_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL wr_counts: got %0d/%0d want 1/0", o_grant_cnt0, o_grant_cnt1);
    end
    n_vec++;
    if (o_m_write !== 1'b0 || o_c0_waitrequest !== 1'b1 || o_c1_waitrequest !== 1'b1) begin
      n_err++;
      $display("FAIL wr_back_idle: got wr=%b w0=%b w1=%b want 0/1/1", o_m_write, o_c0_waitrequest, o_c1_waitrequest);
    end
  endtask

  task automatic check_order(input string tag, input int n, input int first);
    n_vec++;
    if (acc_log.size() != n) begin
      n_err++;
      $display("FAIL %s_order_len: got %0d grants want %0d", tag, acc_log.size(), n);
    end
    for (int i = 0; i < acc_log.size() && i < n; i++) begin
      n_vec++;
      if (acc_log[i] != ((first + i) % 2)) begin
        n_err++;
        $display("FAIL %s_order[%0d]: got master %0d want %0d", tag, i, acc_log[i], (first + i) % 2);
      end
    end
  endtask

  task automatic check_counts(input string tag, input logic [31:0] c0, input logic [31:0] c1);
    n_vec++;
    if (o_grant_cnt0 !== c0 || o_grant_cnt1 !== c1) begin
      n_err++;
      $display("FAIL %s_counts: got %0d/%0d want %0d/%0d", tag, o_grant_cnt0, o_grant_cnt1, c0, c1);
    end
  endtask

  task automatic test_both_read();
    do_reset();
    fork
      master_txn(0, 1'b1, 1'b0, 26'h01, '0);
      master_txn(1, 1'b1, 1'b0, 26'h02, '0);
    join
    drain("both_read");
    check_order("both_read", 2, 0);
    check_counts("both_read", 32'd1, 32'd1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      for (int i = 0; i < 4; i++) master_txn(0, 1'b0, 1'b1, 26'h100 + 26'(i), {4{$urandom()}});
      for (int j = 0; j < 4; j++) master_txn(1, 1'b1, 1'b0, 26'h200 + 26'(j), '0);
    join
    drain("b2b");
    check_order("b2b", 8, 0);
    check_counts("b2b", 32'd4, 32'd4);
  endtask

  task automatic test_stall();
    logic [DW-1:0] d;
    do_reset();
    d = {4{32'h5A5A_0033}};
    stall_left = 5;
    fork
      master_txn(0, 1'b0, 1'b1, 26'h33, d);
      master_txn(1, 1'b1, 1'b0, 26'h44, '0);
      begin
        @(posedge clk);
        repeat (5) begin
          @(negedge clk);
          n_vec++;
          if (o_m_write !== 1'b1 || o_m_read !== 1'b0 || o_m_addr !== 26'h33 || o_m_writedata !== d) begin
            n_err++;
            $display("FAIL stall_cmd: got wr=%b rd=%b a=%h want wr=1 rd=0 a=33", o_m_write, o_m_read, o_m_addr);
          end
          n_vec++;
          if (o_c0_waitrequest !== 1'b1 || o_c1_waitrequest !== 1'b1) begin
            n_err++;
            $display("FAIL stall_wait: got w0=%b w1=%b want 1/1", o_c0_waitrequest, o_c1_waitrequest);
          end
        end
      end
    join
    drain("stall");
    check_order("stall", 2, 0);
  endtask

  task automatic test_withdraw();
    do_reset();
    stall_left = 4;
    fork
      master_txn(0, 1'b0, 1'b1, 26'h60, {4{32'hC0DE_0060}});
      begin
        drive(1, 1'b1, 1'b0, 26'h61, be_of(26'h61), '0);
        repeat (2) @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
      end
    join
    drain("withdraw");
    check_order("withdraw", 1, 0);
    check_counts("withdraw", 32'd1, 32'd0);
  endtask

  task automatic test_reset_rdata();
    cmd_t e;
    do_reset();
    mem_lat = 2;
    e.rd = 1'b1; e.wr = 1'b0; e.addr = 26'h55; e.be = be_of(26'h55); e.data = '0;
    cmdq0.push_back(e);
    drive(0, 1'b1, 1'b0, e.addr, e.be, '0);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (o_m_read !== 1'b1) begin
      n_err++;
      $display("FAIL rst_rd_cmd: got rd=%b want 1", o_m_read);
    end
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (o_m_read !== 1'b0 || o_c0_waitrequest !== 1'b1 || o_c0_readdata_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rdata_state: got rd=%b w0=%b v0=%b want 0/1/0", o_m_read, o_c0_waitrequest, o_c0_readdata_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({o_c0_readdata_valid, o_c1_readdata_valid, o_c0_waitrequest, o_c1_waitrequest,
         o_m_read, o_m_write} !== 6'b001100) begin
      n_err++;
      $display("FAIL rst_drop_valid: got v0=%b v1=%b w0=%b w1=%b rd=%b wr=%b want 001100",
               o_c0_readdata_valid, o_c1_readdata_valid, o_c0_waitrequest, o_c1_waitrequest, o_m_read, o_m_write);
    end
    check_counts("rst_rdata", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_proto_err();
    do_reset();
    fork
      master_txn(1, 1'b1, 1'b1, 26'h77, {4{32'hDEAD_0077}});
      begin
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (o_m_write !== 1'b1 || o_m_read !== 1'b0) begin
          n_err++;
          $display("FAIL perr_cmd: got wr=%b rd=%b want 1/0", o_m_write, o_m_read);
        end
        n_vec++;
        if (o_proto_err !== 1'b1) begin
          n_err++;
          $display("FAIL perr_set: got %b want 1", o_proto_err);
        end
      end
    join
    drain("perr");
    repeat (3) @(negedge clk);
    n_vec++;
    if (o_proto_err !== 1'b1) begin
      n_err++;
      $display("FAIL perr_sticky: got %b want 1", o_proto_err);
    end
    check_counts("perr", 32'd0, 32'd1);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_both_read();
    test_back_to_back();
    test_stall();
    test_withdraw();
    test_reset_rdata();
    test_proto_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cache_mem_arbiter
